// File: rtl/booth4_seq_mult_ctrl_if.sv
// Handshake bundle between a requester and the sequential radix-4 Booth multiplier.
// The requester side presents operands and accepts products; the multiplier side
// reports readiness, the resolved product and its busy status.
interface booth4_seq_mult_ctrl_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/booth4_seq_mult_ctrl.sv
// Sequential 16x16 signed radix-4 Booth multiplier controller.
// A single 2*WIDTH-bit 4:2 compressor row is reused for WIDTH/4 cycles, each cycle
// folding two Booth partial products into a carry-save sum/carry pair; a final
// carry-propagate add produces the product, which is held until handed off.
// Negative partial products are formed as the ones' complement of the shifted
// multiple; their +1 corrections enter the row at bit 0, one as the carry-in of the
// row's internal first-level carry chain and one in the free LSB of the new carry vector.
module booth4_seq_mult_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                   sys_clk,
  input logic                   sys_rst,
  booth4_seq_mult_ctrl_if.slave bus
);

  localparam int ITER  = WIDTH / 4;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COMPRESS,
    RESOLVE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   b_q, b_d;
  logic [PW-1:0]    sum_q, sum_d;
  logic [PW-1:0]    carry_q, carry_d;
  logic [PW-1:0]    product_q, product_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    pp_lo, pp_hi;
  logic             neg_lo, neg_hi;
  logic [PW-1:0]    s1, c1_sh;
  logic [PW-2:0]    c1, c2;
  logic [PW-1:0]    row_sum, row_carry;

  // Booth digit decode: returns {negate, shifted multiple}, the multiple already
  // complemented when the digit is negative (the +1 is added elsewhere).
  function automatic logic [PW:0] booth_pp(input logic [2:0]    trip,
                                           input logic [PW-1:0] mcand,
                                           input int unsigned   shamt);
    logic [PW-1:0] mag;
    logic          neg;
    mag = '0;
    neg = 1'b0;
    case (trip)
      3'b001, 3'b010: begin mag = mcand;      neg = 1'b0; end
      3'b011:         begin mag = mcand << 1; neg = 1'b0; end
      3'b100:         begin mag = mcand << 1; neg = 1'b1; end
      3'b101, 3'b110: begin mag = mcand;      neg = 1'b1; end
      default:        begin mag = '0;         neg = 1'b0; end
    endcase
    return {neg, neg ? ~(mag << shamt) : (mag << shamt)};
  endfunction

  // Shared compressor row: two Booth partial products for the current count plus
  // the registered carry-save pair reduced to a new sum/carry, top carries dropped.
  always_comb begin : row_comb
    int unsigned base;
    base  = 32'(cnt_q) << 2;
    a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    {neg_lo, pp_lo} = booth_pp(b_q[base +: 3], a_ext, base);
    {neg_hi, pp_hi} = booth_pp(b_q[base + 2 +: 3], a_ext, base + 2);
    s1        = sum_q ^ carry_q ^ pp_lo;
    c1        = (sum_q[PW-2:0] & carry_q[PW-2:0]) |
                (sum_q[PW-2:0] & pp_lo[PW-2:0])   |
                (carry_q[PW-2:0] & pp_lo[PW-2:0]);
    c1_sh     = {c1, neg_lo};
    row_sum   = s1 ^ pp_hi ^ c1_sh;
    c2        = (s1[PW-2:0] & pp_hi[PW-2:0])    |
                (s1[PW-2:0] & c1_sh[PW-2:0])    |
                (pp_hi[PW-2:0] & c1_sh[PW-2:0]);
    row_carry = {c2, neg_hi};
  end

  // Next-state and handshake outputs; every register holds unless its state updates it.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    sum_d         = sum_q;
    carry_d       = carry_q;
    cnt_d         = cnt_q;
    product_d     = product_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = {bus.b, 1'b0};
          sum_d   = '0;
          carry_d = '0;
          cnt_d   = '0;
          state_d = COMPRESS;
        end
      end
      COMPRESS: begin
        sum_d   = row_sum;
        carry_d = row_carry;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        product_d = sum_q + carry_q;
        state_d   = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.product = product_q;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
      product_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_booth4_seq_mult_ctrl.sv
// Self-checking bench for booth4_seq_mult_ctrl. Expected products come from plain
// signed integer multiplication; timing expectations from the handshake rules.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_booth4_seq_mult_ctrl;

  localparam int WIDTH = 16;
  localparam int ITER  = WIDTH / 4;
  localparam int PW    = 2 * WIDTH;
  localparam int N_B2B = 1000;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   checks = 0;
  int   errors = 0;

  booth4_seq_mult_ctrl_if #(.WIDTH(WIDTH)) bus ();

  booth4_seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  // Free-running clock
  always #5 sys_clk = ~sys_clk;

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[PW-1:0];
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic pickOperand(output logic [WIDTH-1:0] v);
    case ($urandom_range(0, 9))
      0:       v = 16'h8000;
      1:       v = 16'h0000;
      2:       v = 16'h7FFF;
      3:       v = 16'hFFFF;
      default: v = WIDTH'($urandom);
    endcase
  endtask

  // Present an operand pair, wait (bounded) until it is taken, return just after
  // the accepting edge with in_valid dropped and the operand bus scrambled.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    int budget;
    budget       = 0;
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    while (!bus.in_ready && budget < 50) begin
      tick();
      budget++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    bus.b        = WIDTH'($urandom);
  endtask

  // lat numbers edges with the accepting edge as edge 1.
  task automatic waitResult(input string tag, input logic [PW-1:0] exp, output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) checkOutput({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    checkOutput({tag, "_product"}, 64'(bus.product), 64'(exp));
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic [PW-1:0] exp);
    int lat;
    bus.out_ready = 1'b1;
    applyStimulus(av, bv);
    waitResult(tag, exp, lat);
    tick();
  endtask

  initial begin
    logic [WIDTH-1:0] av, bv, nx_a, nx_b, cur_a, cur_b;
    logic [PW-1:0]    exp_hold;
    logic [PW-1:0]    exp_q[$];
    int lat, stale, done_cnt, issued, cyc, last_acc;
    logic accept;

    sys_rst       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst_in_ready",  64'(bus.in_ready),  64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_busy",      64'(bus.busy),      64'd0);
    checkOutput("rst_product",   64'(bus.product),   64'd0);
    sys_rst = 1'b0;
    tick();

    // Small product, latency and post-handshake status
    bus.out_ready = 1'b1;
    applyStimulus(16'd3, 16'd5);
    checkOutput("t1_busy",     64'(bus.busy),     64'd1);
    checkOutput("t1_in_ready", 64'(bus.in_ready), 64'd0);
    waitResult("t1", 32'h0000000F, lat);
    checkOutput("t1_latency", 64'(lat), 64'(ITER + 2));
    tick();
    checkOutput("t1_valid_after", 64'(bus.out_valid), 64'd0);
    checkOutput("t1_busy_after",  64'(bus.busy),      64'd0);
    checkOutput("t1_ready_after", 64'(bus.in_ready),  64'd1);

    // Boundary operands
    runOp("t2_minmin", 16'h8000, 16'h8000, 32'h40000000);
    runOp("t2_neg1",   16'hFFFF, 16'h0001, 32'hFFFFFFFF);
    runOp("t3_maxmin", 16'h7FFF, 16'h8000, 32'hC0008000);
    runOp("t3_bzero",  16'h1234, 16'h0000, 32'h00000000);

    // Backpressure in DONE while the requester keeps presenting new operands
    bus.out_ready = 1'b0;
    av = WIDTH'($urandom);
    bv = WIDTH'($urandom);
    exp_hold = ref_mul(av, bv);
    applyStimulus(av, bv);
    waitResult("t4", exp_hold, lat);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = WIDTH'($urandom);
      bus.b        = WIDTH'($urandom);
      tick();
      checkOutput("t4_hold_valid",   64'(bus.out_valid), 64'd1);
      checkOutput("t4_hold_product", 64'(bus.product),   64'(exp_hold));
      checkOutput("t4_hold_ready",   64'(bus.in_ready),  64'd0);
    end
    nx_a = WIDTH'($urandom_range(1, 32767));
    nx_b = WIDTH'($urandom_range(1, 32767));
    bus.out_ready = 1'b1;
    applyStimulus(nx_a, nx_b);
    waitResult("t4_next", ref_mul(nx_a, nx_b), lat);
    tick();

    // Asynchronous reset in the middle of the third compress cycle
    bus.out_ready = 1'b1;
    applyStimulus(WIDTH'($urandom_range(1, 32767)), WIDTH'($urandom_range(1, 32767)));
    tick();
    tick();
    #3;
    sys_rst = 1'b1;
    #1;
    checkOutput("t5_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("t5_product",   64'(bus.product),   64'd0);
    checkOutput("t5_in_ready",  64'(bus.in_ready),  64'd1);
    checkOutput("t5_busy",      64'(bus.busy),      64'd0);
    #2;
    sys_rst = 1'b0;
    stale = 0;
    repeat (20) begin
      tick();
      if (bus.out_valid) stale++;
    end
    checkOutput("t5_no_stale", 64'(stale), 64'd0);

    // Back-to-back random traffic with random downstream backpressure
    done_cnt = 0;
    issued   = 0;
    cyc      = 0;
    last_acc = -1;
    pickOperand(cur_a);
    pickOperand(cur_b);
    bus.in_valid = 1'b1;
    bus.a        = cur_a;
    bus.b        = cur_b;
    while (done_cnt < N_B2B && cyc < 40000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) checkOutput("b2b_unexpected", 64'(bus.out_valid), 64'd0);
        else checkOutput("b2b_product", 64'(bus.product), 64'(exp_q.pop_front()));
        done_cnt++;
      end
      accept = bus.in_valid && bus.in_ready;
      if (accept) begin
        exp_q.push_back(ref_mul(cur_a, cur_b));
        if (last_acc >= 0) checkOutput("b2b_spacing", 64'((cyc - last_acc) >= ITER + 3), 64'd1);
        last_acc = cyc;
        issued++;
      end
      tick();
      cyc++;
      if (accept) begin
        if (issued < N_B2B) begin
          pickOperand(cur_a);
          pickOperand(cur_b);
          bus.a = cur_a;
          bus.b = cur_b;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    checkOutput("b2b_completed", 64'(done_cnt), 64'(N_B2B));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
